// File: rtl/detector_jogada_if.sv
// Player-side bus of detector_jogada: raw buttons and control inputs in,
// registered move code and status strobes out.
interface detector_jogada_if #(
    parameter int N_BOT = 4
);
    logic [N_BOT-1:0] botoes;
    logic             habilita;
    logic             zera_timeout;
    logic [N_BOT-1:0] jogada;
    logic             jogada_feita;
    logic             jogada_invalida;
    logic             timeout;

    modport master (
        output botoes, habilita, zera_timeout,
        input  jogada, jogada_feita, jogada_invalida, timeout
    );

    modport slave (
        input  botoes, habilita, zera_timeout,
        output jogada, jogada_feita, jogada_invalida, timeout
    );
endinterface

// File: rtl/detector_jogada.sv
// Button front end: synchronise, debounce, validate one-hot moves,
// emit one-cycle move/invalid strobes and run the per-move timeout.
module detector_jogada #(
    parameter int N_BOT    = 4,
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 5000
) (
    input logic               clock,
    input logic               reset,
    detector_jogada_if.slave  bus
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        LIVRE,
        EMITE,
        INVALIDO,
        AGUARDA_SOLTAR
    } state_t;

    logic [N_BOT-1:0] s1, s2, candidato, estavel, jogada_q;
    logic [DW-1:0]    db_cnt;
    logic [TW-1:0]    to_cnt;
    logic             timeout_q;
    state_t           state, state_next;
    logic             carrega, feita, invalida;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            candidato <= '0;
            db_cnt    <= '0;
            estavel   <= '0;
        end else begin
            s1 <= bus.botoes;
            s2 <= s1;
            if (s2 != candidato) begin
                candidato <= s2;
                db_cnt    <= '0;
            end else if (db_cnt == DB_LAST) begin
                // counter saturates here; estavel keeps tracking the candidate
                estavel <= candidato;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        carrega    = 1'b0;
        feita      = 1'b0;
        invalida   = 1'b0;
        case (state)
            LIVRE: begin
                if (estavel != '0) begin
                    if (!bus.habilita) begin
                        state_next = AGUARDA_SOLTAR;
                    end else if ($onehot(estavel)) begin
                        state_next = EMITE;
                        carrega    = 1'b1;
                    end else begin
                        state_next = INVALIDO;
                    end
                end
            end
            EMITE: begin
                feita      = 1'b1;
                state_next = AGUARDA_SOLTAR;
            end
            INVALIDO: begin
                invalida   = 1'b1;
                state_next = AGUARDA_SOLTAR;
            end
            AGUARDA_SOLTAR: begin
                if (estavel == '0) state_next = LIVRE;
            end
            default: state_next = LIVRE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= LIVRE;
            jogada_q <= '0;
        end else begin
            state <= state_next;
            if (carrega) jogada_q <= estavel;
        end
    end

    // Clear and a captured move both take priority over the terminal count.
    always_ff @(posedge clock) begin
        if (reset || bus.zera_timeout) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (carrega) begin
            to_cnt <= '0;
        end else if (bus.habilita && !timeout_q) begin
            if (to_cnt == TO_LAST) begin
                timeout_q <= 1'b1;
                to_cnt    <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign bus.jogada          = jogada_q;
    assign bus.jogada_feita    = feita;
    assign bus.jogada_invalida = invalida;
    assign bus.timeout         = timeout_q;
endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with DEBOUNCE=4, TIMEOUT=20.
module tb_detector_jogada;
    logic clock = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_both   = 0;
    int   nf, ni, ff, fi, extra;
    logic       tmo_hist [0:127];
    logic [3:0] jog_hist [0:127];

    always #5 clock = ~clock;

    detector_jogada_if #(.N_BOT(4)) bus ();

    detector_jogada #(
        .N_BOT(4),
        .DEBOUNCE(4),
        .TIMEOUT(20)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (bus.jogada_feita && bus.jogada_invalida) n_both++;
    endtask

    // Runs n cycles, recording strobe counts, first strobe index and history.
    task automatic run(input int n);
        nf = 0; ni = 0; ff = -1; fi = -1;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.jogada_feita) begin
                nf++;
                if (ff < 0) ff = i;
            end
            if (bus.jogada_invalida) begin
                ni++;
                if (fi < 0) fi = i;
            end
            tmo_hist[i] = bus.timeout;
            jog_hist[i] = bus.jogada;
        end
    endtask

    initial begin
        // Reset with a button held
        reset = 1'b1;
        bus.botoes = 4'b0100;
        bus.habilita = 1'b0;
        bus.zera_timeout = 1'b0;
        step();
        step();
        check("rst_jogada", 32'(bus.jogada), 32'h0);
        check("rst_feita", 32'(bus.jogada_feita), 32'h0);
        check("rst_invalida", 32'(bus.jogada_invalida), 32'h0);
        check("rst_timeout", 32'(bus.timeout), 32'h0);
        reset = 1'b0;
        run(12);
        bus.habilita = 1'b1;
        run(15);
        check("held_no_feita", 32'(nf), 32'd0);
        check("held_no_invalida", 32'(ni), 32'd0);
        check("held_timeout", 32'(bus.timeout), 32'h0);

        // Release, then a valid press held for 50 more cycles
        bus.zera_timeout = 1'b1;
        bus.botoes = 4'b0000;
        run(8);
        bus.zera_timeout = 1'b0;
        bus.botoes = 4'b0010;
        run(58);
        check("valid_first_edge", 32'(ff), 32'd7);
        check("valid_feita_count", 32'(nf), 32'd1);
        check("valid_no_invalida", 32'(ni), 32'd0);
        check("valid_jogada_before", 32'(jog_hist[6]), 32'h0);
        check("valid_jogada_after", 32'(jog_hist[7]), 32'h2);
        check("tmo_after_move_19", 32'(tmo_hist[26]), 32'h0);
        check("tmo_after_move_20", 32'(tmo_hist[27]), 32'h1);
        check("tmo_sticky", 32'(tmo_hist[57]), 32'h1);

        // Timeout clear, expiry, stickiness and clear-at-terminal-count
        bus.zera_timeout = 1'b1;
        step();
        bus.zera_timeout = 1'b0;
        check("tmo_cleared", 32'(bus.timeout), 32'h0);
        run(19);
        check("tmo_19_cycles", 32'(bus.timeout), 32'h0);
        step();
        check("tmo_20_cycles", 32'(bus.timeout), 32'h1);
        run(5);
        check("tmo_stays_high", 32'(bus.timeout), 32'h1);
        check("tmo_no_strobe", 32'(nf + ni), 32'd0);
        bus.zera_timeout = 1'b1;
        step();
        bus.zera_timeout = 1'b0;
        check("tmo_cleared2", 32'(bus.timeout), 32'h0);
        run(19);
        bus.zera_timeout = 1'b1;
        step();
        bus.zera_timeout = 1'b0;
        check("tmo_clear_wins", 32'(bus.timeout), 32'h0);
        step();
        check("tmo_clear_wins_next", 32'(bus.timeout), 32'h0);

        // Invalid two-button press
        bus.zera_timeout = 1'b1;
        bus.botoes = 4'b0000;
        run(8);
        bus.zera_timeout = 1'b0;
        bus.botoes = 4'b0101;
        run(20);
        check("inv_first_edge", 32'(fi), 32'd7);
        check("inv_count", 32'(ni), 32'd1);
        check("inv_no_feita", 32'(nf), 32'd0);
        check("inv_jogada_kept", 32'(jog_hist[19]), 32'h2);
        check("inv_tmo_18", 32'(tmo_hist[18]), 32'h0);
        check("inv_tmo_not_cleared", 32'(tmo_hist[19]), 32'h1);

        // Bouncing input then stable hold
        bus.zera_timeout = 1'b1;
        bus.botoes = 4'b0000;
        run(8);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            bus.botoes = ((i % 4) < 2) ? 4'b1000 : 4'b0000;
            step();
            if (bus.jogada_feita || bus.jogada_invalida) extra++;
        end
        check("bounce_no_strobe", 32'(extra), 32'd0);
        bus.zera_timeout = 1'b0;
        bus.botoes = 4'b1000;
        run(12);
        check("bounce_first_edge", 32'(ff), 32'd7);
        check("bounce_feita_count", 32'(nf), 32'd1);
        check("bounce_jogada", 32'(jog_hist[11]), 32'h8);

        // Disabled for 100 cycles, counter frozen at 10
        bus.zera_timeout = 1'b1;
        bus.botoes = 4'b0000;
        run(8);
        bus.zera_timeout = 1'b0;
        run(10);
        bus.habilita = 1'b0;
        extra = 0;
        for (int i = 0; i < 100; i++) begin
            bus.botoes = ((i % 25) < 15) ? 4'b0001 : 4'b0000;
            step();
            if (bus.jogada_feita || bus.jogada_invalida || bus.timeout) extra++;
        end
        check("disable_quiet", 32'(extra), 32'd0);
        bus.habilita = 1'b1;
        run(9);
        check("resume_tmo_19", 32'(bus.timeout), 32'h0);
        check("resume_no_strobe", 32'(nf + ni), 32'd0);
        step();
        check("resume_tmo_20", 32'(bus.timeout), 32'h1);

        check("never_both_strobes", 32'(n_both), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
